// File: rtl/datapath_pkg.sv
// ============================================================================
// Module      : datapath_pkg
// Description : Shared datapath types and default sizing for the writeback
//               stage (result entry layout, FU / write-port defaults).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package datapath_pkg;

  localparam int NUM_FU_DEF       = 4;
  localparam int NUM_WB_PORTS_DEF = 1;
  localparam int DATA_W_DEF       = 32;
  localparam int REG_W_DEF        = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [REG_W_DEF-1:0]  regbits_t;

  // One buffered register write: destination index plus result value
  typedef struct packed {
    regbits_t rd;
    word_t    data;
  } wb_entry_t;

endpackage : datapath_pkg

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module      : wb_fifo
// Description : Small circular FIFO holding pending results of one FU.
//               Separate occupancy counter, naturally wrapping pointers,
//               synchronous flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Guard against overflow/underflow even if the caller misbehaves
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // Storage array: no reset needed, validity is tracked by the counter
  always_ff @(posedge CLK) begin
    if (!flush && w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count as is
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : wb_fifo

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module      : wb_arbiter
// Description : Multi-FU writeback stage. Buffers each FU result in its own
//               FIFO and drains FIFO heads onto NUM_WB_PORTS register-file
//               write ports with a round-robin arbiter that never lets two
//               ports write the same register in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
  import datapath_pkg::*;
#(
  parameter int NUM_FU       = NUM_FU_DEF,
  parameter int NUM_WB_PORTS = NUM_WB_PORTS_DEF,
  parameter int FIFO_DEPTH   = 2,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int REG_W        = REG_W_DEF
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      flush,
  input  logic [NUM_FU-1:0]                         fu_valid,
  input  logic [NUM_FU-1:0][REG_W-1:0]              fu_rd,
  input  logic [NUM_FU-1:0][DATA_W-1:0]             fu_data,
  output logic [NUM_FU-1:0]                         fu_ready,
  output logic [NUM_WB_PORTS-1:0]                   wb_en,
  output logic [NUM_WB_PORTS-1:0][REG_W-1:0]        wb_rd,
  output logic [NUM_WB_PORTS-1:0][DATA_W-1:0]       wb_data,
  output logic [$clog2(NUM_FU*FIFO_DEPTH+1)-1:0]    wb_pending
);

  localparam int RR_W   = $clog2(NUM_FU);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PEND_W = $clog2(NUM_FU*FIFO_DEPTH+1);
  localparam int ENT_W  = REG_W + DATA_W;

  logic [NUM_FU-1:0]                   w_push;
  logic [NUM_FU-1:0]                   w_pop;
  logic [NUM_FU-1:0]                   w_full;
  logic [NUM_FU-1:0]                   w_empty;
  logic [NUM_FU-1:0]                   w_grant;
  logic [NUM_FU-1:0][ENT_W-1:0]        w_head;
  logic [NUM_FU-1:0][CNT_W-1:0]        w_count;
  logic [RR_W-1:0]                     r_rr_ptr;
  logic [RR_W-1:0]                     w_rr_next;
  logic                                w_any_grant;
  logic [NUM_WB_PORTS-1:0]             w_en;
  logic [NUM_WB_PORTS-1:0][REG_W-1:0]  w_rd;
  logic [NUM_WB_PORTS-1:0][DATA_W-1:0] w_data;
  logic [PEND_W-1:0]                   w_pending;

  // Ready only looks at the registered count, so a full FIFO stays not-ready
  // in the cycle it is being drained
  assign fu_ready = ~w_full;

  // Grants are discarded while flushing
  assign w_pop = w_grant & ~{NUM_FU{flush}};

  generate
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      // Writes to x0 are accepted but never buffered
      assign w_push[i] = fu_valid[i] & ~w_full[i] & (fu_rd[i] != '0) & ~flush;

      wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .flush (flush),
        .push  (w_push[i]),
        .pop   (w_pop[i]),
        .din   ({fu_rd[i], fu_data[i]}),
        .head  (w_head[i]),
        .count (w_count[i]),
        .full  (w_full[i]),
        .empty (w_empty[i])
      );
    end
  endgenerate

  // Round-robin scan from rr_ptr, filling ports in order and skipping heads
  // whose destination is already being written this cycle
  always_comb begin : arb
    int              used;
    logic            conflict;
    logic [RR_W:0]   scan;
    logic [RR_W-1:0] idx;
    logic [RR_W-1:0] last;
    w_grant     = '0;
    w_en        = '0;
    w_rd        = '0;
    w_data      = '0;
    w_any_grant = 1'b0;
    w_rr_next   = r_rr_ptr;
    used        = 0;
    last        = '0;
    conflict    = 1'b0;
    scan        = '0;
    idx         = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, r_rr_ptr} + (RR_W+1)'(k);
      if (scan >= (RR_W+1)'(NUM_FU)) begin
        scan = scan - (RR_W+1)'(NUM_FU);
      end
      idx = scan[RR_W-1:0];
      if (!w_empty[idx] && (used < NUM_WB_PORTS)) begin
        conflict = 1'b0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
          if ((p < used) && (w_rd[p] == w_head[idx][ENT_W-1:DATA_W])) begin
            conflict = 1'b1;
          end
        end
        if (!conflict) begin
          for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (p == used) begin
              w_en[p]   = 1'b1;
              w_rd[p]   = w_head[idx][ENT_W-1:DATA_W];
              w_data[p] = w_head[idx][DATA_W-1:0];
            end
          end
          w_grant[idx] = 1'b1;
          w_any_grant  = 1'b1;
          last         = idx;
          used         = used + 1;
        end
      end
    end
    if (w_any_grant) begin
      if (({1'b0, last} + (RR_W+1)'(1)) >= (RR_W+1)'(NUM_FU)) begin
        w_rr_next = '0;
      end else begin
        w_rr_next = last + RR_W'(1);
      end
    end
  end

  // Write ports go quiet during a flush cycle
  assign wb_en   = flush ? '0 : w_en;
  assign wb_rd   = flush ? '0 : w_rd;
  assign wb_data = flush ? '0 : w_data;

  // Round-robin pointer moves past the last FIFO served this cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr_ptr <= '0;
    end else if (flush) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // Total buffered entries, built only from the registered FIFO counts
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_pending = w_pending + PEND_W'(w_count[i]);
    end
  end

  assign wb_pending = w_pending;

endmodule : wb_arbiter

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter. Instance A has
//               one write port, instance B has two (rd conflict scenario).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  // Instance A: 4 FUs, 1 write port
  logic             a_flush;
  logic [3:0]       a_valid;
  logic [3:0][4:0]  a_rd;
  logic [3:0][31:0] a_data;
  logic [3:0]       a_ready;
  logic [0:0]       a_wb_en;
  logic [0:0][4:0]  a_wb_rd;
  logic [0:0][31:0] a_wb_data;
  logic [3:0]       a_pend;

  // Instance B: 4 FUs, 2 write ports
  logic             b_flush;
  logic [3:0]       b_valid;
  logic [3:0][4:0]  b_rd;
  logic [3:0][31:0] b_data;
  logic [3:0]       b_ready;
  logic [1:0]       b_wb_en;
  logic [1:0][4:0]  b_wb_rd;
  logic [1:0][31:0] b_wb_data;
  logic [3:0]       b_pend;

  int total;
  int bad;

  wb_arbiter #(
    .NUM_FU(4), .NUM_WB_PORTS(1), .FIFO_DEPTH(2), .DATA_W(32), .REG_W(5)
  ) u_dut_a (
    .CLK(CLK), .RST(RST), .flush(a_flush),
    .fu_valid(a_valid), .fu_rd(a_rd), .fu_data(a_data), .fu_ready(a_ready),
    .wb_en(a_wb_en), .wb_rd(a_wb_rd), .wb_data(a_wb_data), .wb_pending(a_pend)
  );

  wb_arbiter #(
    .NUM_FU(4), .NUM_WB_PORTS(2), .FIFO_DEPTH(2), .DATA_W(32), .REG_W(5)
  ) u_dut_b (
    .CLK(CLK), .RST(RST), .flush(b_flush),
    .fu_valid(b_valid), .fu_rd(b_rd), .fu_data(b_data), .fu_ready(b_ready),
    .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .wb_pending(b_pend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    RST     = 1'b0;
    a_flush = 1'b0; a_valid = '0; a_rd = '0; a_data = '0;
    b_flush = 1'b0; b_valid = '0; b_rd = '0; b_data = '0;

    // ---------------- reset state ----------------
    #1 RST = 1'b1;
    #1;
    chk("rst_ready", a_ready, 4'hF);
    chk("rst_en", a_wb_en, 1'b0);
    chk("rst_rd", a_wb_rd, 5'd0);
    chk("rst_data", a_wb_data, 32'd0);
    chk("rst_pend", a_pend, 4'd0);
    chk("rst_b_en", b_wb_en, 2'b00);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // ---------------- round robin, 2 entries per FU ----------------
    a_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_rd[i]   = 5'(i + 1);
      a_data[i] = 32'hA000_0000 + 32'(i * 16);
    end
    tick();
    for (int i = 0; i < 4; i++) a_data[i] = 32'hA000_0000 + 32'(i * 16 + 1);
    #1;
    chk("rr0_en", a_wb_en, 1'b1);
    chk("rr0_rd", a_wb_rd, 5'd1);
    chk("rr0_data", a_wb_data, 32'hA000_0000);
    chk("rr0_pend", a_pend, 4'd4);
    chk("rr0_ready", a_ready, 4'hF);
    tick();
    a_valid = '0;
    for (int g = 1; g < 8; g++) begin
      int fu;
      int en;
      fu = g % 4;
      en = g / 4;
      #1;
      chk("rr_en", a_wb_en, 1'b1);
      chk("rr_rd", a_wb_rd, 64'(fu + 1));
      chk("rr_data", a_wb_data, 64'(32'hA000_0000 + 32'(fu * 16 + en)));
      chk("rr_pend", a_pend, 64'(8 - g));
      tick();
    end
    #1;
    chk("rr_idle_en", a_wb_en, 1'b0);
    chk("rr_idle_pend", a_pend, 4'd0);

    // ---------------- backpressure on FU2 ----------------
    a_valid = 4'b0101;
    a_rd[0] = 5'd10; a_data[0] = 32'hB0;
    a_rd[2] = 5'd20; a_data[2] = 32'hC0;
    tick();
    a_data[0] = 32'hB1;
    a_data[2] = 32'hC1;
    #1;
    chk("bp1_rd", a_wb_rd, 5'd10);
    chk("bp1_data", a_wb_data, 32'hB0);
    chk("bp1_pend", a_pend, 4'd2);
    chk("bp1_ready", a_ready, 4'hF);
    tick();
    a_valid[0] = 1'b0;
    a_data[2]  = 32'hC2;
    #1;
    chk("bp2_ready", a_ready, 4'b1011);
    chk("bp2_rd", a_wb_rd, 5'd20);
    chk("bp2_data", a_wb_data, 32'hC0);
    chk("bp2_pend", a_pend, 4'd3);
    tick();
    #1;
    chk("bp3_ready", a_ready, 4'hF);
    chk("bp3_rd", a_wb_rd, 5'd10);
    chk("bp3_data", a_wb_data, 32'hB1);
    chk("bp3_pend", a_pend, 4'd2);
    tick();
    a_valid = '0;
    #1;
    chk("bp4_ready", a_ready, 4'b1011);
    chk("bp4_data", a_wb_data, 32'hC1);
    chk("bp4_pend", a_pend, 4'd2);
    tick();
    #1;
    chk("bp5_data", a_wb_data, 32'hC2);
    chk("bp5_pend", a_pend, 4'd1);
    tick();
    #1;
    chk("bp6_en", a_wb_en, 1'b0);
    chk("bp6_pend", a_pend, 4'd0);

    // ---------------- x0 discard ----------------
    a_valid   = 4'b0010;
    a_rd[1]   = 5'd0;
    a_data[1] = 32'hDEAD;
    #1;
    chk("x0_ready", a_ready, 4'hF);
    tick();
    a_valid = '0;
    #1;
    chk("x0_pend", a_pend, 4'd0);
    chk("x0_en", a_wb_en, 1'b0);
    tick();
    chk("x0_en2", a_wb_en, 1'b0);

    // ---------------- flush with simultaneous push ----------------
    a_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_rd[i]   = 5'(i + 1);
      a_data[i] = 32'hD000_0000 + 32'(i);
    end
    tick();
    a_valid = 4'b0111;
    for (int i = 0; i < 3; i++) a_data[i] = 32'hD000_0010 + 32'(i);
    #1;
    chk("fl1_en", a_wb_en, 1'b1);
    chk("fl1_rd", a_wb_rd, 5'd4);
    chk("fl1_data", a_wb_data, 32'hD000_0003);
    chk("fl1_pend", a_pend, 4'd4);
    tick();
    a_valid   = 4'b1000;
    a_rd[3]   = 5'd30;
    a_data[3] = 32'hEEEE;
    a_flush   = 1'b1;
    #1;
    chk("fl2_pend", a_pend, 4'd6);
    chk("fl2_en", a_wb_en, 1'b0);
    chk("fl2_rd", a_wb_rd, 5'd0);
    chk("fl2_data", a_wb_data, 32'd0);
    tick();
    a_flush = 1'b0;
    a_valid = '0;
    #1;
    chk("fl3_pend", a_pend, 4'd0);
    chk("fl3_en", a_wb_en, 1'b0);
    chk("fl3_ready", a_ready, 4'hF);
    tick();
    chk("fl4_en", a_wb_en, 1'b0);

    // ---------------- rd conflict, two write ports ----------------
    b_valid = 4'b0111;
    b_rd[0] = 5'd7; b_data[0] = 32'h70;
    b_rd[1] = 5'd7; b_data[1] = 32'h71;
    b_rd[2] = 5'd9; b_data[2] = 32'h92;
    tick();
    b_valid = '0;
    #1;
    chk("cf1_en", b_wb_en, 2'b11);
    chk("cf1_rd0", b_wb_rd[0], 5'd7);
    chk("cf1_data0", b_wb_data[0], 32'h70);
    chk("cf1_rd1", b_wb_rd[1], 5'd9);
    chk("cf1_data1", b_wb_data[1], 32'h92);
    chk("cf1_pend", b_pend, 4'd3);
    tick();
    #1;
    chk("cf2_en", b_wb_en, 2'b01);
    chk("cf2_rd0", b_wb_rd[0], 5'd7);
    chk("cf2_data0", b_wb_data[0], 32'h71);
    chk("cf2_rd1", b_wb_rd[1], 5'd0);
    chk("cf2_pend", b_pend, 4'd1);
    tick();
    chk("cf3_en", b_wb_en, 2'b00);
    chk("cf3_pend", b_pend, 4'd0);

    // ---------------- asynchronous reset mid-drain ----------------
    a_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_rd[i]   = 5'(i + 1);
      a_data[i] = 32'hF0 + 32'(i);
    end
    tick();
    a_valid = '0;
    #1;
    chk("rm_pre_en", a_wb_en, 1'b1);
    chk("rm_pre_pend", a_pend, 4'd4);
    #2 RST = 1'b1;
    #1;
    chk("rm_en", a_wb_en, 1'b0);
    chk("rm_rd", a_wb_rd, 5'd0);
    chk("rm_data", a_wb_data, 32'd0);
    chk("rm_pend", a_pend, 4'd0);
    chk("rm_ready", a_ready, 4'hF);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    chk("rm_post_en", a_wb_en, 1'b0);
    chk("rm_post_pend", a_pend, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_arbiter

`default_nettype wire
